// File: rtl/sort_pipe_arbiter.sv
// rtl/sort_pipe_arbiter.sv - round-robin front end and credit-protected result FIFO for a shared 4-input sort pipeline
module sort_pipe_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int WIDTH      = 5,
   parameter int PIPE_LAT   = 3,
   parameter int FIFO_DEPTH = 4,
   parameter int IDW        = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*4*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     pipe_in_valid,
   output logic [4*WIDTH-1:0]       pipe_in_data,
   input  logic                     pipe_out_valid,
   input  logic [4*WIDTH-1:0]       pipe_out_data,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [IDW-1:0]           rsp_id,
   output logic [4*WIDTH-1:0]       rsp_data,
   input  logic                     err_clr,
   output logic                     err_unexpected,
   output logic                     err_missing
);
   localparam int DW = 4 * WIDTH;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [CW-1:0]  credits;
   logic [IDW-1:0] rr_ptr;
   logic           gnt_found;
   logic [IDW-1:0] gnt_idx;
   logic           accept;
   logic           pop;

   // First valid requester at or after rr_ptr, wrapping.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!gnt_found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
            gnt_found = 1'b1;
            gnt_idx   = IDW'((int'(rr_ptr) + k) % NUM_REQ);
         end
      end
   end

   // Gated by rst_n so no grant is shown while reset is held.
   assign accept = rst_n && gnt_found && (credits != '0);

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[gnt_idx] = 1'b1;
   end

   assign pop = rsp_valid && rsp_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credits       <= CW'(FIFO_DEPTH);
         rr_ptr        <= '0;
         pipe_in_valid <= 1'b0;
         pipe_in_data  <= '0;
      end else begin
         pipe_in_valid <= accept;
         if (accept) begin
            pipe_in_data <= req_data[gnt_idx*DW +: DW];
            rr_ptr       <= (gnt_idx == IDW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
         end
         if (accept && !pop)
            credits <= credits - 1'b1;
         else if (pop && !accept && credits != CW'(FIFO_DEPTH))
            credits <= credits + 1'b1;
      end
   end

   // Tag line: last stage lines up with the sorter's output register.
   logic [PIPE_LAT:0] tag_v;
   logic [IDW-1:0]    tag_id [0:PIPE_LAT];
   logic              last_v;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_v <= '0;
         for (int k = 0; k <= PIPE_LAT; k++) tag_id[k] <= '0;
      end else begin
         tag_v     <= {tag_v[PIPE_LAT-1:0], accept};
         tag_id[0] <= gnt_idx;
         for (int k = 1; k <= PIPE_LAT; k++) tag_id[k] <= tag_id[k-1];
      end
   end

   assign last_v = tag_v[PIPE_LAT];

   logic [IDW+DW-1:0] mem [FIFO_DEPTH];
   logic [AW:0]       wr_ptr, rd_ptr;
   logic              full, empty, wr_en;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign wr_en = pipe_out_valid && last_v && (!full || pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int k = 0; k < FIFO_DEPTH; k++) mem[k] <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {tag_id[PIPE_LAT], pipe_out_data};
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   assign rsp_valid          = !empty;
   assign {rsp_id, rsp_data} = mem[rd_ptr[AW-1:0]];

   logic set_unexp, set_miss;
   assign set_unexp = pipe_out_valid && (!last_v || (full && !pop));
   assign set_miss  = last_v && !pipe_out_valid;

   // A new error in the clearing cycle takes priority over err_clr.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_unexpected <= 1'b0;
         err_missing    <= 1'b0;
      end else begin
         if (set_unexp)    err_unexpected <= 1'b1;
         else if (err_clr) err_unexpected <= 1'b0;
         if (set_miss)     err_missing    <= 1'b1;
         else if (err_clr) err_missing    <= 1'b0;
      end
   end
endmodule

// File: tb/tb_sort_pipe_arbiter.sv
// tb/tb_sort_pipe_arbiter.sv - scoreboard bench for sort_pipe_arbiter with a 3-register sorter model
module tb_sort_pipe_arbiter;
   localparam int NR = 4, W = 5, DW = 20, IDW = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NR-1:0]     req_valid;
   logic [NR*DW-1:0]  req_data;
   logic [NR-1:0]     req_ready;
   logic              pipe_in_valid;
   logic [DW-1:0]     pipe_in_data;
   logic              pipe_out_valid;
   logic [DW-1:0]     pipe_out_data;
   logic              rsp_valid, rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [DW-1:0]     rsp_data;
   logic              err_clr, err_unexpected, err_missing;
   logic              inj_out, drop_out;

   always #5 clk = ~clk;

   sort_pipe_arbiter #(.NUM_REQ(NR), .WIDTH(W), .PIPE_LAT(3), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .pipe_in_valid(pipe_in_valid), .pipe_in_data(pipe_in_data),
      .pipe_out_valid(pipe_out_valid), .pipe_out_data(pipe_out_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .err_clr(err_clr), .err_unexpected(err_unexpected), .err_missing(err_missing)
   );

   function automatic logic [DW-1:0] sort4(input logic [DW-1:0] d);
      logic [W-1:0] v [4];
      logic [W-1:0] t;
      for (int i = 0; i < 4; i++) v[i] = d[DW-1-i*W -: W];
      for (int a = 0; a < 3; a++)
         for (int b = 0; b < 3 - a; b++)
            if (v[b] < v[b+1]) begin t = v[b]; v[b] = v[b+1]; v[b+1] = t; end
      return {v[0], v[1], v[2], v[3]};
   endfunction

   // External sorter: capture, two more registers, output register three edges after pipe_in.
   logic [2:0]    sv;
   logic [DW-1:0] sd [3];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sv <= '0; sd[0] <= '0; sd[1] <= '0; sd[2] <= '0;
      end else begin
         sv <= {sv[1:0], pipe_in_valid};
         sd[0] <= sort4(pipe_in_data); sd[1] <= sd[0]; sd[2] <= sd[1];
      end
   end
   assign pipe_out_valid = (sv[2] && !drop_out) || inj_out;
   assign pipe_out_data  = sd[2];

   function automatic logic [DW-1:0] pk(input int a, input int b, input int c, input int d);
      logic [W-1:0] x0, x1, x2, x3;
      x0 = W'(a); x1 = W'(b); x2 = W'(c); x3 = W'(d);
      return {x0, x1, x2, x3};
   endfunction

   logic [DW-1:0] vin [6];
   logic [DW-1:0] vexp [6];
   logic [DW-1:0] cur_exp [NR];
   logic [IDW+DW-1:0] exp_q [$];
   int total = 0, bad = 0, acc_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_req(input int i, input int v);
      req_data[i*DW +: DW] = vin[v];
      cur_exp[i] = vexp[v];
   endtask

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   // Accept monitor: push the expected response when a grant is visible.
   always @(negedge clk) begin
      if (rst_n)
         for (int i = 0; i < NR; i++)
            if (req_ready[i] && req_valid[i]) begin
               exp_q.push_back({IDW'(i), cur_exp[i]});
               acc_cnt++;
            end
   end

   // Response monitor: compare every handshake with the scoreboard head.
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL rsp_extra: got id=%0d data=%0h expected nothing", rsp_id, rsp_data);
         end else begin
            check("rsp", {10'b0, rsp_id, rsp_data}, {10'b0, exp_q.pop_front()});
         end
      end
   end

   task automatic do_reset();
      rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0; err_clr = 1'b0;
      inj_out = 1'b0; drop_out = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      cyc();
   endtask

   task automatic wait_drain();
      int n;
      for (n = 0; n < 100; n++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !rsp_valid) break;
      end
      check("drain", exp_q.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      int n, a, k;
      vin[0] = pk(1, 2, 3, 4);     vexp[0] = pk(4, 3, 2, 1);
      vin[1] = pk(10, 30, 20, 0);  vexp[1] = pk(30, 20, 10, 0);
      vin[2] = pk(3, 17, 9, 31);   vexp[2] = pk(31, 17, 9, 3);
      vin[3] = pk(31, 0, 16, 8);   vexp[3] = pk(31, 16, 8, 0);
      vin[4] = pk(0, 31, 31, 0);   vexp[4] = pk(31, 31, 0, 0);
      vin[5] = pk(5, 5, 5, 5);     vexp[5] = pk(5, 5, 5, 5);
      req_data = '0;
      for (int i = 0; i < NR; i++) set_req(i, i);

      // Reset state with all requesters asking
      rst_n = 1'b0; req_valid = '1; rsp_ready = 1'b0; err_clr = 1'b0;
      inj_out = 1'b0; drop_out = 1'b0;
      #12;
      check("rst_req_ready", req_ready, 0);
      check("rst_pipe_in_valid", pipe_in_valid, 0);
      check("rst_pipe_in_data", pipe_in_data, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp", {rsp_id, rsp_data}, 0);
      check("rst_errs", {err_unexpected, err_missing}, 0);
      do_reset();

      // Single job from requester 2
      set_req(2, 2); req_valid = 4'b0100; rsp_ready = 1'b1;
      @(negedge clk) check("single_grant", req_ready, 4'b0100);
      @(posedge clk); #1 req_valid = '0;
      n = 0;
      while (n < 20) begin
         @(posedge clk); n++;
         @(negedge clk);
         if (rsp_valid) break;
      end
      check("single_latency", n, 4);
      check("single_id", rsp_id, 2);
      check("single_data", rsp_data, pk(31, 17, 9, 3));
      wait_drain();

      // Round robin with all requesters valid
      do_reset();
      for (int i = 0; i < NR; i++) set_req(i, i);
      req_valid = '1; rsp_ready = 1'b1;
      k = 0;
      for (n = 0; n < 60 && k < 8; n++) begin
         @(negedge clk);
         if (req_ready != 0) begin
            check("rr_grant", req_ready, 32'(1 << (k % 4)));
            k++;
         end
      end
      check("rr_count", k, 8);
      @(posedge clk); #1 req_valid = '0;
      wait_drain();

      // Credits and backpressure
      do_reset();
      req_valid = '1; rsp_ready = 1'b0;
      a = acc_cnt;
      repeat (12) cyc();
      check("bp_accepts", acc_cnt - a, 4);
      @(negedge clk);
      check("bp_stalled", req_ready, 0);
      check("bp_rsp_valid", rsp_valid, 1);
      @(posedge clk); #1 rsp_ready = 1'b1;
      a = acc_cnt;
      @(posedge clk); #1 rsp_ready = 1'b0;
      @(negedge clk) check("bp_credit_back", req_ready, 4'b0001);
      repeat (8) cyc();
      check("bp_one_more", acc_cnt - a, 1);
      req_valid = '0; rsp_ready = 1'b1;
      wait_drain();
      check("bp_errs", {err_unexpected, err_missing}, 0);

      // Ties and extremes
      set_req(3, 4); req_valid = 4'b1000; cyc(); req_valid = '0;
      set_req(0, 5); req_valid = 4'b0001; cyc(); req_valid = '0;
      wait_drain();

      // Error detection
      do_reset();
      rsp_ready = 1'b1;
      inj_out = 1'b1; cyc(); inj_out = 1'b0;
      @(negedge clk);
      check("unexp_set", err_unexpected, 1);
      check("unexp_no_rsp", rsp_valid, 0);
      cyc(); err_clr = 1'b1; cyc(); err_clr = 1'b0;
      @(negedge clk) check("unexp_clr", err_unexpected, 0);
      cyc(); inj_out = 1'b1; err_clr = 1'b1; cyc(); inj_out = 1'b0; err_clr = 1'b0;
      @(negedge clk) check("set_beats_clr", err_unexpected, 1);
      cyc(); err_clr = 1'b1; cyc(); err_clr = 1'b0;
      drop_out = 1'b1;
      set_req(1, 1); req_valid = 4'b0010; cyc(); req_valid = '0;
      repeat (6) cyc();
      drop_out = 1'b0;
      @(negedge clk);
      check("missing_set", err_missing, 1);
      check("missing_no_rsp", rsp_valid, 0);
      check("missing_unexp_clear", err_unexpected, 0);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
      @(posedge clk); #1;
      rsp_ready = 1'b0; req_valid = '1;
      for (int i = 0; i < NR; i++) set_req(i, i);
      a = acc_cnt;
      repeat (10) cyc();
      check("lost_credit", acc_cnt - a, 3);
      req_valid = '0; rsp_ready = 1'b1;
      wait_drain();

      // Reset with work in flight
      do_reset();
      for (int i = 0; i < NR; i++) set_req(i, i);
      req_valid = 4'b0001; cyc(); req_valid = '0;
      for (n = 0; n < 20; n++) begin
         @(negedge clk);
         if (rsp_valid) break;
      end
      check("mid_first_in_fifo", rsp_valid, 1);
      @(posedge clk); #1 req_valid = 4'b1110;
      repeat (3) cyc();
      rst_n = 1'b0;
      #1;
      check("mid_rsp_valid", rsp_valid, 0);
      check("mid_pipe_in_valid", pipe_in_valid, 0);
      check("mid_req_ready", req_ready, 0);
      exp_q.delete();
      req_valid = '0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1 req_valid = '1; rsp_ready = 1'b1;
      @(negedge clk) check("mid_rr_ptr0", req_ready, 4'b0001);
      @(posedge clk); #1 req_valid = '0;
      wait_drain();
      check("final_errs", {err_unexpected, err_missing}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
